fpu_core: RTL and testbench
===========================

# fpu_core

Single-precision (IEEE-754 binary32) floating-point arithmetic unit providing add, subtract and multiply with four rounding modes and IEEE exception flags. It is a fully pipelined, two-cycle-latency datapath block used as the arithmetic engine of the processor's FP execution slot. Operands and opcode are presented every cycle, and a result with its flags emerges two rising edges later.

## Interface
Parameters: none.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rmode`  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- `fpu_op`  in  3  opcode: 0 add, 1 sub (a-b), 2 mul, 3 div (reserved), 4-7 reserved.
- `opa`  in  32  operand a.
- `opb`  in  32  operand b.
- `out`  out  32  result.
- `inf`  out  1  out is ±infinity.
- `snan`  out  1  either operand is a signalling NaN.
- `qnan`  out  1  out is NaN.
- `ine`  out  1  result inexact (rounding lost bits, or overflow/underflow occurred).
- `overflow`  out  1  rounded magnitude exceeds 0x7F7FFFFF.
- `underflow`  out  1  nonzero result below the normal range, flushed to zero.
- `zero`  out  1  out is ±0.
- `div_by_zero`  out  1  fpu_op=3 and opb is ±0.

## Operation
- Denormal inputs are treated as signed zero (flush-to-zero). Denormal results are flushed to signed zero with underflow=1 and ine=1.
- Add/sub: align exponents, keeping guard, round and sticky bits. Add or subtract mantissas, normalise with a leading-zero count, then round per rmode. Sub is add with the sign of b inverted.
- Exact-zero sum: +0, except for rmode 11, which gives -0. The sum (-0)+(-0) gives -0.
- Mul: sign = sa^sb. 24x24 mantissa product, exponent = ea+eb-127, normalise by 0 or 1 bit, then round.
- Rounding: nearest-even rounds on G&(R|S|LSB). +inf/-inf modes round up the magnitude when any of G/R/S is set and the sign matches the mode. A mantissa carry-out increments the exponent.
- Overflow result by rounding mode:
  - RNE: ±inf.
  - RTZ: ±0x7F7FFFFF.
  - +inf mode: +inf for positive results, -max-finite for negative results.
  - -inf mode: the mirror of +inf mode.
  - Overflow always sets overflow=1 and ine=1.
- Specials:
  - Any NaN input, inf-inf (effective subtraction), 0*inf: out=0x7FC00000 (canonical qNaN), qnan=1.
  - snan=1 if any input has exponent 0xFF, a nonzero mantissa and mantissa bit 22 = 0.
  - An infinite operand otherwise yields correctly signed infinity, with inf=1 and overflow=0.
- Reserved ops (3-7): out=0x7FC00000, qnan=1, all other flags 0, except div_by_zero as defined in the interface.
- Flags are mutually consistent with out: zero iff out[30:0]=0; inf iff out[30:0]=0x7F800000; qnan iff exponent 0xFF with nonzero mantissa.

## Timing
- Stage 1 registers the decoded operands, opcode and rmode, and computes the alignment/product. Stage 2 normalises and rounds; its output register drives `out` and all flags.
- Latency is 2 rising edges from input sample to output. Throughput is one op per cycle, with no stalls and no handshake.
- Reset (asynchronous) clears both stages. While rst is asserted: `out`=0x00000000 and every flag is 0, including `zero`. The first valid output appears 2 edges after rst deasserts.
- Reset asserted mid-pipeline discards in-flight ops.

## Configuration
- `FPU_MUL_EN` defined: multiply (op 2) is implemented as specified.
- `FPU_MUL_EN` not defined: the multiplier is omitted, and op 2 behaves as a reserved op (0x7FC00000, qnan=1). Add/sub are unaffected.

## Test plan
- Assert rst for 3 cycles with random inputs -> out=0x00000000 and all flags 0 throughout. Release rst -> first result appears 2 edges later.
- op0, rmode 00, a=0x3F800000, b=0x40000000 -> out=0x40400000 two cycles later, all flags 0.
- op1, a=b=0x3F800000: rmode 00 -> 0x00000000 with zero=1; rmode 11 -> 0x80000000 with zero=1.
- op2, a=0x7F000000, b=0x40000000: rmode 00 -> 0x7F800000 with inf, overflow and ine set; rmode 01 -> 0x7F7FFFFF with overflow and ine set, inf=0.
- op0, a=0x7F800000, b=0xFF800000 -> 0x7FC00000 with qnan=1, snan=0. a=0x7F800001, b=0x3F800000 -> 0x7FC00000 with qnan=1 and snan=1.
- Back-to-back stream: add, mul, op3 with b=0, op3 with b=0x3F800000, one per cycle -> results in order, 2 cycles late. The op3 results are 0x7FC00000, with div_by_zero=1 for the first op3 only.

Source files
------------

// File: rtl/fpu_core.sv
// fpu_core: two-stage IEEE-754 binary32 add/sub/mul with four rounding modes and flush-to-zero.
// Define FPU_MUL_EN to build the multiplier; without it op 2 behaves like a reserved op.
module fpu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] out,
  output logic        inf,
  output logic        snan,
  output logic        qnan,
  output logic        ine,
  output logic        overflow,
  output logic        underflow,
  output logic        zero,
  output logic        div_by_zero
);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;
  localparam logic [30:0] MAX_MAG = 31'h7F7F_FFFF;
  localparam logic [1:0]  RM_RNE  = 2'b00;
  localparam logic [1:0]  RM_RTZ  = 2'b01;
  localparam logic [1:0]  RM_RUP  = 2'b10;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] cnt;
    cnt = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) cnt = 5'(26 - i);
    return cnt;
  endfunction

  logic        sa, sb, sb_eff;
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, snan_in;
  logic [23:0] ma_h, mb_h;
  logic        is_add, is_sub, is_mul;

  assign sa      = opa[31];
  assign sb      = opb[31];
  assign ea      = opa[30:23];
  assign eb      = opb[30:23];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (opa[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (opb[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (opa[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (opb[22:0] != 23'd0);
  assign ma_h    = a_zero ? 24'd0 : {1'b1, opa[22:0]};
  assign mb_h    = b_zero ? 24'd0 : {1'b1, opb[22:0]};
  assign snan_in = (a_nan && !opa[22]) || (b_nan && !opb[22]);
  assign is_add  = (fpu_op == 3'd0);
  assign is_sub  = (fpu_op == 3'd1);
  assign sb_eff  = sb ^ is_sub;

  logic        a_ge, eff_sub, sticky, s_big, add_sign;
  logic [7:0]  e_big, e_small, diff;
  logic [23:0] m_big, m_small;
  logic [26:0] sm_ext, sm_sh, aligned;
  logic [27:0] add_sum;

  // Larger magnitude goes first so the mantissa difference can never go negative.
  always_comb begin
    a_ge    = {ea, ma_h[22:0]} >= {eb, mb_h[22:0]};
    e_big   = a_ge ? ea : eb;
    e_small = a_ge ? eb : ea;
    m_big   = a_ge ? ma_h : mb_h;
    m_small = a_ge ? mb_h : ma_h;
    s_big   = a_ge ? sa : sb_eff;
    eff_sub = sa ^ sb_eff;
    diff    = e_big - e_small;
    sm_ext  = {m_small, 3'b000};
    sm_sh   = sm_ext >> diff;
    sticky  = |(sm_ext & ~(27'h7FF_FFFF << diff));
    aligned = {sm_sh[26:1], sm_sh[0] | sticky};
    add_sum = eff_sub ? ({1'b0, m_big, 3'b000} - {1'b0, aligned})
                      : ({1'b0, m_big, 3'b000} + {1'b0, aligned});
    if (add_sum == 28'd0)
      add_sign = (sa == sb_eff) ? sa : (rmode == 2'b11);
    else
      add_sign = s_big;
  end

  logic [47:0] prod;
  logic [27:0] mul_sum;
  logic [9:0]  mul_exp;

`ifdef FPU_MUL_EN
  assign is_mul = (fpu_op == 3'd2);
  assign prod   = {24'd0, ma_h} * {24'd0, mb_h};
`else
  assign is_mul = 1'b0;
  assign prod   = 48'd0;
`endif
  assign mul_sum = {prod[47:21], |prod[20:0]};
  assign mul_exp = {2'b00, ea} + {2'b00, eb} - 10'd127;

  logic        spec, spec_snan, spec_dbz;
  logic [31:0] spec_out;

  always_comb begin
    spec      = 1'b0;
    spec_out  = QNAN;
    spec_snan = 1'b0;
    spec_dbz  = 1'b0;
    if (is_add || is_sub) begin
      spec_snan = snan_in;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb_eff))) begin
        spec = 1'b1;
      end else if (a_inf) begin
        spec     = 1'b1;
        spec_out = {sa, INF_MAG};
      end else if (b_inf) begin
        spec     = 1'b1;
        spec_out = {sb_eff, INF_MAG};
      end
    end else if (is_mul) begin
      spec_snan = snan_in;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
        spec = 1'b1;
      end else if (a_inf || b_inf) begin
        spec     = 1'b1;
        spec_out = {sa ^ sb, INF_MAG};
      end else if (a_zero || b_zero) begin
        spec     = 1'b1;
        spec_out = {sa ^ sb, 31'd0};
      end
    end else begin
      spec     = 1'b1;
      spec_dbz = (fpu_op == 3'd3) && b_zero;
    end
  end

  logic               s1_valid, s1_special, s1_snan, s1_dbz, s1_sign;
  logic [31:0]        s1_spec_out;
  logic [27:0]        s1_sum;
  logic signed [9:0]  s1_exp;
  logic [1:0]         s1_rmode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_special  <= 1'b0;
      s1_snan     <= 1'b0;
      s1_dbz      <= 1'b0;
      s1_sign     <= 1'b0;
      s1_spec_out <= 32'd0;
      s1_sum      <= 28'd0;
      s1_exp      <= 10'sd0;
      s1_rmode    <= 2'b00;
    end else begin
      s1_valid    <= 1'b1;
      s1_special  <= spec;
      s1_snan     <= spec_snan;
      s1_dbz      <= spec_dbz;
      s1_sign     <= is_mul ? (sa ^ sb) : add_sign;
      s1_spec_out <= spec_out;
      s1_sum      <= is_mul ? mul_sum : add_sum;
      s1_exp      <= is_mul ? mul_exp : {2'b00, e_big};
      s1_rmode    <= rmode;
    end
  end

  logic [4:0]        lz;
  logic [26:0]       n;
  logic signed [9:0] en, er;
  logic              lost, rnd_up;
  logic [24:0]       m_rnd;
  logic [22:0]       frac;

  // n holds hidden bit at [26], fraction at [25:3], guard/round/sticky at [2:0].
  always_comb begin
    lz = lzc27(s1_sum[26:0]);
    if (s1_sum[27]) begin
      n  = {s1_sum[27:2], s1_sum[1] | s1_sum[0]};
      en = s1_exp + 10'sd1;
    end else begin
      n  = s1_sum[26:0] << lz;
      en = s1_exp - $signed({5'd0, lz});
    end
    lost = |n[2:0];
    case (s1_rmode)
      RM_RNE:  rnd_up = n[2] & (n[1] | n[0] | n[3]);
      RM_RTZ:  rnd_up = 1'b0;
      RM_RUP:  rnd_up = lost & ~s1_sign;
      default: rnd_up = lost & s1_sign;
    endcase
    m_rnd = {1'b0, n[26:3]} + {24'd0, rnd_up};
    frac  = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
    er    = en + $signed({9'd0, m_rnd[24]});
  end

  logic [31:0] nxt_out;
  logic        nxt_ine, nxt_ovf, nxt_unf;

  always_comb begin
    nxt_out = 32'd0;
    nxt_ine = 1'b0;
    nxt_ovf = 1'b0;
    nxt_unf = 1'b0;
    if (!s1_valid) begin
      nxt_out = 32'd0;
    end else if (s1_special) begin
      nxt_out = s1_spec_out;
    end else if (s1_sum == 28'd0) begin
      nxt_out = {s1_sign, 31'd0};
    end else if (er >= 10'sd255) begin
      nxt_ovf = 1'b1;
      nxt_ine = 1'b1;
      case (s1_rmode)
        RM_RNE:  nxt_out = {s1_sign, INF_MAG};
        RM_RTZ:  nxt_out = {s1_sign, MAX_MAG};
        RM_RUP:  nxt_out = {s1_sign, s1_sign ? MAX_MAG : INF_MAG};
        default: nxt_out = {s1_sign, s1_sign ? INF_MAG : MAX_MAG};
      endcase
    end else if (er <= 10'sd0) begin
      nxt_unf = 1'b1;
      nxt_ine = 1'b1;
      nxt_out = {s1_sign, 31'd0};
    end else begin
      nxt_out = {s1_sign, er[7:0], frac};
      nxt_ine = lost;
    end
  end

  // Class flags are derived from the result word itself so they always agree with out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out         <= 32'd0;
      inf         <= 1'b0;
      snan        <= 1'b0;
      qnan        <= 1'b0;
      ine         <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out         <= nxt_out;
      inf         <= s1_valid && (nxt_out[30:0] == INF_MAG);
      qnan        <= s1_valid && (nxt_out[30:23] == 8'hFF) && (nxt_out[22:0] != 23'd0);
      zero        <= s1_valid && (nxt_out[30:0] == 31'd0);
      snan        <= s1_valid && s1_snan;
      div_by_zero <= s1_valid && s1_dbz;
      ine         <= nxt_ine;
      overflow    <= nxt_ovf;
      underflow   <= nxt_unf;
    end
  end

endmodule

// File: tb/tb_fpu_core.sv
// tb_fpu_core: directed scoreboard bench for fpu_core; expectations are hand-derived constants
// queued at issue time and compared when the two-cycle pipeline delivers them.
module tb_fpu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rmodeIn;
  logic [2:0]  fpuOp;
  logic [31:0] opaIn, opbIn;
  logic [31:0] out;
  logic        inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero;
  logic [7:0]  flagVec;

  always #5 clk = ~clk;

  fpu_core dut (
    .clk(clk), .rst(rst), .rmode(rmodeIn), .fpu_op(fpuOp), .opa(opaIn), .opb(opbIn),
    .out(out), .inf(inf), .snan(snan), .qnan(qnan), .ine(ine), .overflow(overflow),
    .underflow(underflow), .zero(zero), .div_by_zero(div_by_zero)
  );

  assign flagVec = {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero};

  localparam logic [7:0] F_INF  = 8'h80;
  localparam logic [7:0] F_SNAN = 8'h40;
  localparam logic [7:0] F_QNAN = 8'h20;
  localparam logic [7:0] F_INE  = 8'h10;
  localparam logic [7:0] F_OVF  = 8'h08;
  localparam logic [7:0] F_UNF  = 8'h04;
  localparam logic [7:0] F_ZERO = 8'h02;
  localparam logic [7:0] F_DBZ  = 8'h01;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

`ifdef FPU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct {
    bit          chk;
    logic [31:0] eOut;
    logic [7:0]  eFlg;
    int          id;
  } expect_t;

  expect_t expQ[$];
  int total = 0;
  int bad = 0;
  int stepId = 0;

  task automatic compareResult(input logic [31:0] wantOut, input logic [7:0] wantFlg, input int id);
    total++;
    assert (out === wantOut) else begin
      bad++;
      $error("[TB] FAIL out step%0d got=%08h want=%08h", id, out, wantOut);
    end
    total++;
    assert (flagVec === wantFlg) else begin
      bad++;
      $error("[TB] FAIL flags step%0d got=%08b want=%08b", id, flagVec, wantFlg);
    end
  endtask

  // Two entries in flight means the oldest one is now on the outputs.
  task automatic checkOutput();
    expect_t e;
    if (expQ.size() >= 2) begin
      e = expQ.pop_front();
      if (e.chk) compareResult(e.eOut, e.eFlg, e.id);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] wantOut,
                               input logic [7:0] wantFlg, input bit chk);
    expect_t e;
    checkOutput();
    fpuOp   = op;
    rmodeIn = rm;
    opaIn   = a;
    opbIn   = b;
    stepId++;
    e.chk  = chk;
    e.eOut = wantOut;
    e.eFlg = wantFlg;
    e.id   = stepId;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    fpuOp = 3'd0; rmodeIn = 2'd0; opaIn = 32'd0; opbIn = 32'd0;
    repeat (3) begin
      fpuOp   = 3'($urandom_range(0, 7));
      rmodeIn = 2'($urandom_range(0, 3));
      opaIn   = $urandom;
      opbIn   = $urandom;
      @(negedge clk);
      compareResult(32'h00000000, 8'h00, 0);
    end
    rst = 1'b0;
    fpuOp = 3'd0; rmodeIn = 2'd0; opaIn = 32'd0; opbIn = 32'd0;

    applyStimulus(3'd0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 8'h00, 1);
    applyStimulus(3'd1, 2'd0, 32'h3F800000, 32'h3F800000, 32'h00000000, F_ZERO, 1);
    applyStimulus(3'd1, 2'd3, 32'h3F800000, 32'h3F800000, 32'h80000000, F_ZERO, 1);
    applyStimulus(3'd2, 2'd0, 32'h7F000000, 32'h40000000, MUL_ON ? 32'h7F800000 : QNAN,
                  MUL_ON ? (F_INF | F_INE | F_OVF) : F_QNAN, 1);
    applyStimulus(3'd2, 2'd1, 32'h7F000000, 32'h40000000, MUL_ON ? 32'h7F7FFFFF : QNAN,
                  MUL_ON ? (F_INE | F_OVF) : F_QNAN, 1);
    applyStimulus(3'd0, 2'd0, 32'h7F800000, 32'hFF800000, QNAN, F_QNAN, 1);
    applyStimulus(3'd0, 2'd0, 32'h7F800001, 32'h3F800000, QNAN, F_QNAN | F_SNAN, 1);
    // back-to-back: add, mul, op3 with b=0, op3 with b=1.0
    applyStimulus(3'd0, 2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 8'h00, 1);
    applyStimulus(3'd2, 2'd0, 32'h40400000, 32'h40000000, MUL_ON ? 32'h40C00000 : QNAN,
                  MUL_ON ? 8'h00 : F_QNAN, 1);
    applyStimulus(3'd3, 2'd0, 32'h3F800000, 32'h00000000, QNAN, F_QNAN | F_DBZ, 1);
    applyStimulus(3'd3, 2'd0, 32'h3F800000, 32'h3F800000, QNAN, F_QNAN, 1);
    // rounding: 1 + 2^-24 is a tie, 1+2^-23 + 2^-24 is a tie with odd LSB
    applyStimulus(3'd0, 2'd0, 32'h3F800000, 32'h33800000, 32'h3F800000, F_INE, 1);
    applyStimulus(3'd0, 2'd2, 32'h3F800000, 32'h33800000, 32'h3F800001, F_INE, 1);
    applyStimulus(3'd0, 2'd1, 32'h3F800000, 32'h33800000, 32'h3F800000, F_INE, 1);
    applyStimulus(3'd0, 2'd0, 32'h3F800001, 32'h33800000, 32'h3F800002, F_INE, 1);
    applyStimulus(3'd0, 2'd3, 32'hBF800000, 32'hB3800000, 32'hBF800001, F_INE, 1);
    // underflow, overflow, denormal input, infinities
    applyStimulus(3'd1, 2'd0, 32'h00800001, 32'h00800000, 32'h00000000, F_ZERO | F_UNF | F_INE, 1);
    applyStimulus(3'd0, 2'd2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, F_INF | F_INE | F_OVF, 1);
    applyStimulus(3'd0, 2'd3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, F_INE | F_OVF, 1);
    applyStimulus(3'd0, 2'd0, 32'h00000001, 32'h3F800000, 32'h3F800000, 8'h00, 1);
    applyStimulus(3'd0, 2'd0, 32'hFF800000, 32'h3F800000, 32'hFF800000, F_INF, 1);
    applyStimulus(3'd1, 2'd0, 32'h3F800000, 32'h7F800000, 32'hFF800000, F_INF, 1);
    applyStimulus(3'd5, 2'd0, 32'h3F800000, 32'h00000000, QNAN, F_QNAN, 1);
    applyStimulus(3'd2, 2'd0, 32'h00000000, 32'h7F800000, QNAN, F_QNAN, 1);
    applyStimulus(3'd2, 2'd0, 32'h80000000, 32'h3F800000, MUL_ON ? 32'h80000000 : QNAN,
                  MUL_ON ? F_ZERO : F_QNAN, 1);
    applyStimulus(3'd0, 2'd1, 32'h3F800000, 32'hBF800000, 32'h00000000, F_ZERO, 1);
    applyStimulus(3'd0, 2'd0, 32'h80000000, 32'h80000000, 32'h80000000, F_ZERO, 1);
    applyStimulus(3'd1, 2'd0, 32'h40400000, 32'h3F800000, 32'h40000000, 8'h00, 1);
    applyStimulus(3'd1, 2'd0, 32'h3FC00000, 32'h3F800000, 32'h3F000000, 8'h00, 1);

    // reset in the middle of a stream discards what was in flight
    #2 rst = 1'b1;
    #1 compareResult(32'h00000000, 8'h00, 900);
    expQ.delete();
    @(negedge clk);
    compareResult(32'h00000000, 8'h00, 901);
    rst = 1'b0;
    applyStimulus(3'd0, 2'd0, 32'h40000000, 32'h40000000, 32'h40800000, 8'h00, 1);
    applyStimulus(3'd1, 2'd0, 32'h40000000, 32'h3F800000, 32'h3F800000, 8'h00, 1);
    applyStimulus(3'd0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 0);
    applyStimulus(3'd0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
